// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types for the program-counter sequencer
// Purpose: FSM state encodings and decoder flow-type codes used by pc_ctrl.
// Ports: none (package).
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BR_SEQ  = 2'b00,
    BR_JMP  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_t;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO
// Purpose: small LIFO of return addresses. Only the occupancy counter is
//   reset by clr; entry storage is left as-is.
// Ports:
//   clk, clr       clock, synchronous active-high reset
//   push, pop      push din / pop top entry (ignored when full / empty)
//   din            value to push
//   dout           current top entry (valid when !empty)
//   full, empty    occupancy status
import pc_ctrl_pkg::*;

module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  cnt;
  logic [PW:0]  top_idx;
  logic [W-1:0] mem [DEPTH];

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = cnt - (PW+1)'(1);
  assign dout    = mem[top_idx[PW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push && !full) begin
      mem[cnt[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch/execute sequencer owning the program counter
// Purpose: drives the PC register load enable and next address, handshakes
//   with instruction memory and the decoder, resolves seq/jump/call/return.
// Ports:
//   clk, clr              clock, synchronous active-high reset
//   pc_in                 current PC (fed back from PC register)
//   adrs_next, en_pc      next PC value and its one-cycle load strobe
//   imem_req, imem_ack    fetch request for pc_in / fetch data valid
//   ir_load               instruction register load strobe
//   br_valid, br_type,
//   br_cond, br_target    decoder flow result (sampled in EXEC only)
//   halt, run, halted     stop after current instruction / resume / status
//   err_ovf, err_unf      sticky call-on-full / return-on-empty flags
import pc_ctrl_pkg::*;

module pc_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] adrs_next,
  output logic              en_pc,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              ir_load,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  input  logic              run,
  output logic              halted,
  output logic              err_ovf,
  output logic              err_unf
);

  state_t            state;
  br_type_t          bt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              do_call;
  logic              do_ret;

  assign bt     = br_type_t'(br_type);
  assign pc_inc = pc_in + ADDR_W'(1);

  // A flow result only takes effect in EXEC with br_cond set; a false
  // condition degrades every type to sequential.
  assign do_call = (state == EXEC) && br_valid && br_cond && (bt == BR_CALL);
  assign do_ret  = (state == EXEC) && br_valid && br_cond && (bt == BR_RET);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (do_call),
    .pop   (do_ret),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Outputs depend on same-cycle handshake inputs (ir_load follows imem_ack,
  // adrs_next follows the decoder result), so they are decoded from state.
  always_comb begin
    en_pc     = 1'b0;
    adrs_next = pc_inc;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    halted    = 1'b0;
    unique case (state)
      INIT: begin
        en_pc     = 1'b1;
        adrs_next = RESET_VEC;
      end
      FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      EXEC: begin
        if (br_valid) begin
          en_pc = 1'b1;
          if (br_cond) begin
            case (bt)
              BR_JMP, BR_CALL: adrs_next = br_target;
              // Return on empty stack falls through to pc_in+1.
              BR_RET: if (!stk_empty) adrs_next = stk_top;
              default: ;
            endcase
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= INIT;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | (do_call & stk_full);
      err_unf <= err_unf | (do_ret & stk_empty);
      unique case (state)
        INIT:  state <= FETCH;
        FETCH: if (imem_ack) state <= EXEC;
        EXEC:  if (br_valid) state <= halt ? HALT : FETCH;
        HALT:  if (run) state <= FETCH;
      endcase
    end
  end

endmodule
